// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage definitions: entry layout, widths and default queue depth.
package instruction_fetch_unit_pkg;

  localparam int unsigned FETCH_QUEUE_DEPTH = 2;
  localparam int unsigned PC_W              = 32;
  localparam int unsigned INSTR_W           = 32;
  localparam logic [PC_W-1:0] PC_INCREMENT  = 32'd4;

  // One captured fetch: the PC and the instruction word returned for it.
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; any low-bit set is a fetch fault.
  function automatic logic pc_misaligned(input logic [PC_W-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-to-decode handshake bundle: head entry presented with valid/ready.
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;

  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc;
  logic [INSTR_W-1:0] out_instruction;

  modport master (output out_valid, output out_pc, output out_instruction, input out_ready);
  modport slave  (input out_valid, input out_pc, input out_instruction, output out_ready);

endinterface

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// Small synchronous FIFO of fetch entries; flush wins over push/pop.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = FETCH_QUEUE_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t push_data_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o,
  output logic         full_o
);

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;
  fetch_entry_t  mem_q [DEPTH];

  // Next pointer/count values; pointers wrap naturally at DEPTH.
  always_comb begin
    pop_ok   = pop_i & (count_q != '0);
    push_ok  = push_i & ((count_q != CW'(DEPTH)) | pop_ok);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; a flushed cycle never writes.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, queues {pc, instruction} pairs, handles redirects/faults.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned     QUEUE_DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic [PC_W-1:0]      imem_pc,
  input  logic [INSTR_W-1:0]   imem_instruction,
  input  logic                 redirect_valid,
  input  logic [PC_W-1:0]      redirect_pc,
  instruction_fetch_unit_if.master out_if,
  output logic                 fetch_fault
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  logic [PC_W-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic            push, pop, full;
  logic [CW-1:0]   count;
  fetch_entry_t    tail_entry, head;

  // Handshake qualification and PC/fault next state; a redirect voids any pop or push.
  always_comb begin
    pop        = out_if.out_valid & out_if.out_ready & ~redirect_valid;
    push       = ~fault_q & ~redirect_valid & (~full | pop);
    tail_entry = '{pc: pc_q, instr: imem_instruction};
    pc_d       = pc_q;
    fault_d    = fault_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      fault_d = pc_misaligned(redirect_pc);
    end else if (push) begin
      pc_d = pc_q + PC_INCREMENT;
    end
  end

  // PC and sticky fault registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (tail_entry),
    .head_o      (head),
    .count_o     (count),
    .full_o      (full)
  );

  assign imem_pc                = pc_q;
  assign fetch_fault            = fault_q;
  assign out_if.out_valid       = (count != '0);
  assign out_if.out_pc          = head.pc;
  assign out_if.out_instruction = head.instr;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized + directed bench for instruction_fetch_unit against a queue-based model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] imem_pc;
  logic [31:0] imem_instruction;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_fault;

  instruction_fetch_unit_if out_if ();

  instruction_fetch_unit #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .imem_pc          (imem_pc),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_if           (out_if),
    .fetch_fault      (fetch_fault)
  );

  always #5 clk = ~clk;

  // Instruction memory: hashed data in low memory and near the top, 0 elsewhere.
  function automatic logic [31:0] imem_f(input logic [31:0] a);
    if (a < 32'h0000_1000 || a >= 32'hFFFF_F000) return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    return 32'h0;
  endfunction

  assign imem_instruction = imem_f(imem_pc);

  // Reference model state
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc = RST_PC;
  logic        m_fault = 1'b0;
  bit          check_en = 0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("valid", {31'b0, out_if.out_valid}, {31'b0, mq.size() > 0});
    chk("out_pc", out_if.out_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
    chk("out_ins", out_if.out_instruction, (mq.size() > 0) ? mq[0].ins : 32'h0);
    chk("imem_pc", imem_pc, m_pc);
    chk("fault", {31'b0, fetch_fault}, {31'b0, m_fault});
  endtask

  task automatic model_update(input logic rn, input logic rdy, input logic rv, input logic [31:0] rpc);
    bit do_pop, do_push;
    if (!rn) begin
      mq.delete();
      m_pc    = RST_PC;
      m_fault = 1'b0;
      return;
    end
    do_pop  = (mq.size() > 0) && rdy && !rv;
    do_push = !m_fault && !rv && ((mq.size() < DEPTH) || do_pop);
    if (rv) begin
      mq.delete();
      m_pc    = rpc;
      m_fault = (rpc % 4) != 0;
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back('{pc: m_pc, ins: imem_f(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // One clock: check settled outputs, drive inputs, advance model at the edge.
  task automatic step(input logic rn, input logic rdy, input logic rv, input logic [31:0] rpc);
    @(negedge clk);
    if (check_en) check_all();
    reset_n           = rn;
    out_if.out_ready  = rdy;
    redirect_valid    = rv;
    redirect_pc       = rpc;
    @(posedge clk);
    model_update(rn, rdy, rv, rpc);
    #1;
  endtask

  initial begin
    logic [31:0] tgt;
    out_if.out_ready = 1'b0;

    // Reset, then streaming with ready high
    step(0, 1, 0, 0);
    check_en = 1;
    step(0, 1, 0, 0);
    chk("rst_valid", {31'b0, out_if.out_valid}, 32'd0);
    chk("rst_pc", imem_pc, RST_PC);
    step(1, 1, 0, 0);
    chk("lat_valid", {31'b0, out_if.out_valid}, 32'd1);
    chk("lat_pc0", out_if.out_pc, 32'h0);
    chk("lat_ins0", out_if.out_instruction, imem_f(32'h0));
    step(1, 1, 0, 0); chk("seq_pc4", out_if.out_pc, 32'h4);
    step(1, 1, 0, 0); chk("seq_pc8", out_if.out_pc, 32'h8);
    step(1, 1, 0, 0); chk("seq_pcC", out_if.out_pc, 32'hC);

    // Backpressure
    step(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    chk("bp_imem", imem_pc, 32'h8);
    chk("bp_head", out_if.out_pc, 32'h0);
    chk("bp_ins", out_if.out_instruction, imem_f(32'h0));
    step(1, 1, 0, 0); chk("bp_pc4", out_if.out_pc, 32'h4);
    step(1, 1, 0, 0); chk("bp_pc8", out_if.out_pc, 32'h8);

    // Redirect with full FIFO and ready high
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(1, 1, 1, 32'h90);
    chk("rd_valid", {31'b0, out_if.out_valid}, 32'd0);
    chk("rd_imem", imem_pc, 32'h90);
    step(1, 1, 0, 0);
    chk("rd_pc", out_if.out_pc, 32'h90);

    // Misaligned redirect, then recovery
    step(1, 1, 1, 32'h92);
    chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0);
      chk("mis_valid", {31'b0, out_if.out_valid}, 32'd0);
      chk("mis_imem", imem_pc, 32'h92);
    end
    step(1, 1, 1, 32'h78);
    chk("fix_fault", {31'b0, fetch_fault}, 32'd0);
    step(1, 1, 0, 0);
    chk("fix_pc", out_if.out_pc, 32'h78);

    // PC wrap
    step(1, 1, 1, 32'hFFFF_FFF8);
    step(1, 1, 0, 0); chk("wrap0", out_if.out_pc, 32'hFFFF_FFF8);
    step(1, 1, 0, 0); chk("wrap1", out_if.out_pc, 32'hFFFF_FFFC);
    step(1, 1, 0, 0); chk("wrap2", out_if.out_pc, 32'h0000_0000);

    // Reset while full
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("mrst_valid", {31'b0, out_if.out_valid}, 32'd0);
    chk("mrst_imem", imem_pc, RST_PC);
    step(1, 1, 0, 0); chk("mrst_pc0", out_if.out_pc, RST_PC);
    step(1, 1, 0, 0); chk("mrst_pc4", out_if.out_pc, RST_PC + 32'd4);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic rn, rdy, rv;
      rn  = ($urandom_range(0, 99) != 0);
      rdy = ($urandom_range(0, 99) < 65);
      rv  = ($urandom_range(0, 99) < 7);
      tgt = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 4) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | {28'h0, 2'($urandom_range(0, 3)), 2'b00};
      step(rn, rdy, rv, tgt);
    end
    step(1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage upstream of the combinational InstructionMemory (pc in, instruction out, same cycle).
- Owns the program counter, drives it to instruction memory, and captures each {pc, instruction} pair into a small FIFO.
- Presents the FIFO head to the decode stage with a valid/ready handshake.
- Handles redirects (branch/jump targets) with flush, and flags misaligned redirect targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- QUEUE_DEPTH, 2, number of fetch FIFO entries (power of two, ≥2).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- imem_pc  output  32  address to instruction memory; equals internal PC register.
- imem_instruction  input  32  instruction memory data for imem_pc, valid same cycle.
- redirect_valid  input  1  redirect request this cycle.
- redirect_pc  input  32  redirect target.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  decode accepts head.
- out_pc  output  32  PC of head entry.
- out_instruction  output  32  instruction of head entry.
- fetch_fault  output  1  sticky misaligned-target flag.

Behaviour:
- Reset (reset_n=0 at edge):
  - pc ← RESET_PC.
  - FIFO emptied.
  - fetch_fault ← 0.
  - out_valid=0; out_pc and out_instruction read 0 while empty.
  - Reset mid-operation discards all entries with no partial output.
- pop = out_valid & out_ready & ~redirect_valid.
- push = ~fetch_fault & ~redirect_valid & (count < QUEUE_DEPTH | pop).
- On push, at the edge:
  - Write {pc, imem_instruction} to tail.
  - pc ← pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- If neither push nor redirect, pc holds.
- Latency: first entry is pushed in the first cycle after reset release. out_valid=1 one cycle later, with out_pc=RESET_PC.
- Steady state: with out_ready held high, one instruction per cycle; PCs are consecutive.
- Full FIFO:
  - A push occurs in the same cycle as a pop.
  - Without a pop, fetch stalls and pc holds.
- Handshake rules:
  - Head fields are stable while out_valid & ~out_ready.
  - out_valid never drops without a pop, redirect, or reset.
- Redirect (redirect_valid=1), all at the edge:
  - FIFO flushed, including any entry that would have been pushed this cycle.
  - A same-cycle pop is discarded: the redirect has priority, and decode must treat its handshake as void.
  - If redirect_pc[1:0]==0: pc ← redirect_pc and fetch_fault ← 0. First post-redirect entry is pushed next cycle, so out_valid rises 2 cycles after the redirect edge cycle.
  - If redirect_pc[1:0]!=0: pc ← redirect_pc and fetch_fault ← 1. No pushes occur while fault=1.
- fetch_fault stays set until an aligned redirect or reset. Redirects during fault follow the same rules.
- Instruction data is passed through unmodified, including 32'h0 returned for out-of-range addresses. No decoding is done here.
- FIFO pointers are log2(QUEUE_DEPTH) bits and wrap naturally; count is log2(QUEUE_DEPTH)+1 bits.

Decomposition:
- Shared package/header fetch.vh:
  - FETCH_QUEUE_DEPTH default.
  - PC_INCREMENT (4).
  - Fetch-entry field widths (PC_W=32, INSTR_W=32).
- One sub-module: fetch_queue.
  - Synchronous FIFO with push/pop/flush, count, head data, full/empty.
  - Flush has priority over push/pop in the same cycle.
- PC register and redirect/fault logic stay in the top module.

Test Plan:
- Reset → release with out_ready=1 → out_valid rises in the 2nd cycle after release; out_pc sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles; out_instruction matches imem model data.
- Backpressure: out_ready=0 for 5 cycles after start → FIFO fills to 2, imem_pc holds 0x8, head stays {0x0, data[0]}; raise out_ready → entries 0x0, 0x4, 0x8 delivered back-to-back.
- Redirect with a full FIFO, redirect_pc=0x90, out_ready=1 in the same cycle → no pop counted; next cycle out_valid=0 and imem_pc=0x90; the cycle after, out_pc=0x90.
- Misaligned redirect_pc=0x92 → fetch_fault=1 next cycle, out_valid stays 0 and imem_pc holds 0x92 for 10 cycles; aligned redirect to 0x78 → fault clears, out_pc=0x78 two cycles later.
- Wrap: redirect to 0xFFFF_FFF8 → out_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset asserted while FIFO full and fault clear → next cycle out_valid=0 and imem_pc=RESET_PC; normal sequence restarts from RESET_PC.
